// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack CPU front end.
package hack_pkg;

  localparam int unsigned PC_W   = 15;
  localparam int unsigned INST_W = 16;

  typedef logic [PC_W-1:0]   pc_t;
  typedef logic [INST_W-1:0] inst_t;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/hack_fetch_if.sv
// ROM read port plus instruction valid/ready channel between fetch and decode.
interface hack_fetch_if #(
  parameter int unsigned PC_W   = hack_pkg::PC_W,
  parameter int unsigned INST_W = hack_pkg::INST_W
);

  logic              rom_req;
  logic [PC_W-1:0]   rom_addr;
  logic              rom_ack;
  logic [INST_W-1:0] rom_data;
  logic [INST_W-1:0] inst;
  logic [PC_W-1:0]   inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              jump;
  logic [PC_W-1:0]   jump_addr;

  modport master (
    output rom_req, rom_addr, inst, inst_pc, inst_valid,
    input  rom_ack, rom_data, inst_ready, jump, jump_addr
  );

  modport slave (
    input  rom_req, rom_addr, inst, inst_pc, inst_valid,
    output rom_ack, rom_data, inst_ready, jump, jump_addr
  );

endinterface

// File: rtl/hack_fetch.sv
// Instruction fetch: owns the PC, keeps one ROM read in flight, and holds the
// fetched word until decode accepts it, applying any jump reported on accept.
module hack_fetch #(
  parameter int unsigned     PC_W     = hack_pkg::PC_W,
  parameter int unsigned     INST_W   = hack_pkg::INST_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  hack_fetch_if.master bus
);

  import hack_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q;
  logic [INST_W-1:0] inst_q;
  logic [PC_W-1:0]   inst_pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (bus.rom_ack)    state_d = HOLD;
      HOLD:    if (bus.inst_ready) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Datapath updates are gated by the current state, so an ack while holding
  // and a jump while stalled never reach the registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (bus.rom_ack) begin
            inst_q    <= bus.rom_data;
            inst_pc_q <= pc_q;
          end
        end
        HOLD: begin
          if (bus.inst_ready) begin
            pc_q <= bus.jump ? bus.jump_addr : inst_pc_q + PC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are pure decodes of registers, so they behave as registered.
  always_comb begin
    bus.rom_req    = (state_q == FETCH);
    bus.inst_valid = (state_q == HOLD);
    bus.rom_addr   = pc_q;
    bus.inst       = inst_q;
    bus.inst_pc    = inst_pc_q;
  end

endmodule

// File: tb/tb_hack_fetch.sv
// Scoreboard bench for hack_fetch: directed scenarios followed by random traffic.
module tb_hack_fetch;

  import hack_pkg::*;

  typedef struct {
    inst_t word;
    pc_t   pc;
  } exp_t;

  logic clk;
  logic rst_n;

  hack_fetch_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

  hack_fetch #(
    .PC_W    (PC_W),
    .INST_W  (INST_W),
    .RESET_PC(15'h0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned checks   = 0;
  int unsigned failures = 0;

  inst_t mem [0:32767];
  exp_t  inst_q [$];

  // Reference model: are we holding an instruction, which address is being
  // fetched, and what the instruction register should currently show.
  bit    armed      = 1'b0;
  bit    holding    = 1'b0;
  pc_t   fetch_addr = '0;
  inst_t shown_inst = '0;
  pc_t   shown_pc   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model advances from the inputs it just applied.
  task automatic step(input logic r, input logic a, input logic rdy,
                      input logic j, input pc_t ja);
    rst_n          = r;
    bus.rom_ack    = a;
    bus.rom_data   = (!holding && a) ? mem[fetch_addr] : inst_t'($urandom);
    bus.inst_ready = rdy;
    bus.jump       = j;
    bus.jump_addr  = ja;
    if (r && !holding && a) inst_q.push_back('{word: mem[fetch_addr], pc: fetch_addr});
    @(posedge clk);
    #1;
    if (!r) begin
      holding    = 1'b0;
      fetch_addr = '0;
      shown_inst = '0;
      shown_pc   = '0;
      inst_q.delete();
    end else if (!holding && a) begin
      holding    = 1'b1;
      shown_inst = mem[fetch_addr];
      shown_pc   = fetch_addr;
    end else if (holding && rdy) begin
      holding    = 1'b0;
      fetch_addr = j ? ja : pc_t'((32'(shown_pc) + 1) % 32768);
    end
    armed = 1'b1;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("rom_req", 32'(bus.rom_req), 32'(!holding));
      chk("inst_valid", 32'(bus.inst_valid), 32'(holding));
      chk("inst_reg", 32'(bus.inst), 32'(shown_inst));
      chk("inst_pc_reg", 32'(bus.inst_pc), 32'(shown_pc));
      if (!holding) chk("rom_addr", 32'(bus.rom_addr), 32'(fetch_addr));
      if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
        if (inst_q.size() == 0) begin
          chk("sb_underflow", 32'(inst_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = inst_q.pop_front();
          chk("accept_inst", 32'(bus.inst), 32'(e.word));
          chk("accept_pc", 32'(bus.inst_pc), 32'(e.pc));
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.rom_ack    = 1'b0;
    bus.rom_data   = '0;
    bus.inst_ready = 1'b0;
    bus.jump       = 1'b0;
    bus.jump_addr  = '0;
    for (int i = 0; i < 32768; i++) mem[i] = inst_t'($urandom);
    mem[0]     = 16'h0005;
    mem[1]     = 16'hEC10;
    mem[5]     = 16'h1234;
    mem[16'h42] = 16'hBEEF;

    // Reset, then zero-wait ROM with decode always ready: addresses 0..3.
    step(0, 1, 1, 0, '0);
    step(0, 0, 0, 0, '0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, '0);

    // Three ROM wait cycles at address 4, then ack and accept.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, '0);
    step(1, 1, 0, 0, '0);
    step(1, 0, 1, 0, '0);

    // Backpressure on 0x1234 at pc 5; a jump during the stall is ignored.
    step(1, 1, 0, 0, '0);
    step(1, 1, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 1, 15'h0100);
    step(1, 1, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(1, 0, 1, 0, '0);

    // Jump to 0x10, then jump on accept from 0x10 to 0x0003.
    step(1, 1, 0, 0, '0);
    step(1, 0, 1, 1, 15'h0010);
    step(1, 1, 0, 0, '0);
    step(1, 0, 1, 1, 15'h0003);
    step(1, 1, 0, 0, '0);

    // Wrap: jump to 0x7FFF, fetch it, accept without jump -> 0x0000.
    step(1, 0, 1, 1, 15'h7FFF);
    step(1, 1, 0, 0, '0);
    step(1, 0, 1, 0, '0);
    step(1, 1, 0, 0, '0);

    // Jump target equal to pc+1.
    step(1, 0, 1, 1, 15'h0001);
    step(1, 1, 0, 0, '0);

    // Reset during a fetch of 0x0042 with ack in the reset cycle.
    step(1, 0, 1, 1, 15'h0042);
    step(0, 1, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, '0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, a, rdy, j;
      pc_t  ja;
      r   = ($urandom_range(0, 99) != 0);
      a   = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 5);
      j   = ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 3))
        0:       ja = pc_t'((32'(shown_pc) + 1) % 32768);
        1:       ja = 15'h7FFF;
        default: ja = pc_t'($urandom);
      endcase
      step(r, a, rdy, j, ja);
    end

    step(1, 0, 0, 0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
